store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side counterpart of the load extraction path: executes sw/sh/sb against a data memory that only supports full-word writes.
- sw is written directly.
- sb/sh use read-modify-write: read the aligned word, merge the new byte or halfword into the selected lane, write the word back.
- Sits between the core's MEM stage and data memory. Core stalls while req_ready=0.

Parameters:
- MEM_RD_LAT, 1, cycles from mem_rd_en to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  store request
- req_ready  out  1  unit idle, request accepted this cycle if req_valid
- addr  in  32  byte address of store
- wdata  in  32  store data; sb uses [7:0], sh uses [15:0]
- store_type_sel  in  2  01=sb, 10=sh, 00/11=sw (same encoding as load type select)
- done  out  1  one-cycle pulse, store committed this cycle
- align_err  out  1  one-cycle pulse, misaligned store dropped (see Optional Feature)
- mem_addr  out  32  word address {addr_q[31:2],2'b00}, 0 when idle
- mem_rd_en  out  1  memory read strobe
- mem_rdata  in  32  memory read data
- mem_wr_en  out  1  memory word write strobe
- mem_wdata  out  32  merged write word

Behaviour:
- Accept = req_valid && req_ready. On accept, latch addr, wdata and type into addr_q, wdata_q and type_q.
- The inputs addr, wdata and store_type_sel are ignored when no accept occurs.
- States: IDLE, READ, WAIT, WRITE, ERR. All outputs are decoded from the state and registers only; there is no combinational path from req_* to mem_*.
- IDLE: req_ready=1.
  - Accepting sw → WRITE.
  - Accepting sb/sh → READ.
  - Misaligned with the feature enabled → ERR.
- READ: mem_rd_en=1 for exactly one cycle (cycle T). Clear the wait counter. Next state is WAIT.
- WAIT: counter increments each cycle.
  - When the counter reaches MEM_RD_LAT, capture mem_rdata into rdata_q at the end of cycle T+MEM_RD_LAT.
  - Next state after the capture is WRITE.
  - Counter width is 3 bits and it never wraps within the legal parameter range.
- WRITE: mem_wr_en=1 and done=1 for one cycle, mem_wdata=merged word. Next state is IDLE.
- ERR: align_err=1 for one cycle, no mem strobes. Next state is IDLE.
- Merge rules:
  - sw: merged = wdata_q.
  - sh: addr_q[1]=0 replaces [15:0]; addr_q[1]=1 replaces [31:16]; the other half is kept from rdata_q.
  - sb: addr_q[1:0] selects lane [7:0]/[15:8]/[23:16]/[31:24], replaced with wdata_q[7:0]; other bytes are kept from rdata_q.
- Latency, with accept at cycle A:
  - sw: WRITE at A+1.
  - sb/sh: READ at A+1, WRITE at A+2+MEM_RD_LAT.
  - Next accept is possible in the cycle after WRITE/ERR.
- mem_addr holds the aligned address in READ, WAIT and WRITE, and is 0 in IDLE and ERR.
- req_valid held high while busy is ignored (req_ready=0). There is no queuing.
- Reset, from any state including mid-read:
  - Next state is IDLE, all registers are cleared, the captured data is discarded and no write is issued.
  - Output values after reset: req_ready=1; done, align_err, mem_rd_en and mem_wr_en = 0; mem_addr and mem_wdata = 0.
- mem_wdata is 0 in every state except WRITE.

Optional Feature:
- STORE_ALIGN_CHECK_EN defined:
  - Misaligned accepts go to ERR with no memory access. Misaligned means sh with addr[0]=1, or sw with addr[1:0]≠00.
  - The following cycle has align_err=1 and done=0.
- Not defined:
  - align_err is tied to 0.
  - Low address bits not used for lane select are ignored: sh uses addr[1] only, sw ignores addr[1:0].
  - The store proceeds normally.

Test Plan:
- sw, addr 0x10, wdata 0xDEADBEEF, type 00 → cycle A+1: mem_wr_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never asserted.
- sb, addr 0x13, wdata 0x000000AB, memory word 0x11223344, MEM_RD_LAT=1 → mem_rd_en at A+1; write at A+3 of 0xAB223344, mem_addr=0x10.
- sh, addr 0x22 then addr 0x20, wdata 0x0000CAFE, memory 0x11223344 → writes 0xCAFE3344 then 0x1122CAFE; second accept is possible at A+4.
- MEM_RD_LAT=3, sb addr 0x01, wdata 0x55, memory 0xFFFFFFFF → WRITE at A+5 of 0xFFFF55FF; req_ready=0 from A+1 through A+5 despite req_valid held high.
- reset asserted during WAIT of an sb → next cycle: IDLE, req_ready=1, no mem_wr_en ever issued for that store.
- sh addr 0x21, memory 0x11223344:
  - with STORE_ALIGN_CHECK_EN: align_err=1 at A+1, no mem strobes, done=0.
  - without: write 0x1122CAFE at A+3.

Source files
------------

// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Executes sw/sh/sb stores against a data memory that only accepts full-word
// writes. sw is written straight through; sb/sh read the aligned word, merge
// the new byte/halfword into the addressed lane and write the word back.
// The core stalls on req_ready=0; there is no request queuing.
//
// Build option:
//   STORE_ALIGN_CHECK_EN  when defined, a misaligned sh (addr[0]=1) or sw
//                         (addr[1:0]!=0) is dropped and reported on align_err.
//                         When undefined, align_err is tied low and unused
//                         low address bits are ignored.
//
// Parameters:
//   MEM_RD_LAT  cycles from mem_rd_en to valid mem_rdata (legal 1..7)
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req_valid        store request from the MEM stage
//   req_ready        unit idle; request accepted this cycle if req_valid
//   addr             byte address of the store
//   wdata            store data (sb uses [7:0], sh uses [15:0])
//   store_type_sel   01=sb, 10=sh, 00/11=sw
//   done             one-cycle pulse: store committed
//   align_err        one-cycle pulse: misaligned store dropped
//   mem_addr         aligned word address, 0 when no access is in flight
//   mem_rd_en        memory read strobe
//   mem_rdata        memory read data
//   mem_wr_en        memory word write strobe
//   mem_wdata        merged write word, 0 outside the write cycle
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_type_sel,
    output logic        done,
    output logic        align_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_ERR
    } state_t;

    localparam logic [1:0] TYPE_SB = 2'b01;
    localparam logic [1:0] TYPE_SH = 2'b10;
    localparam logic [2:0] RD_LAT  = 3'(MEM_RD_LAT);

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  type_q,  type_d;
    logic [2:0]  cnt_q,   cnt_d;

    logic accept;
    logic is_rmw;
    logic misaligned;

    // Lane merge: new data replaces the addressed byte/halfword, the rest of
    // the word comes from the value read back from memory.
    function automatic logic [31:0] merge_word(
        input logic [1:0]  store_type,
        input logic [1:0]  lane,
        input logic [31:0] new_data,
        input logic [31:0] old_word
    );
        logic [31:0] w;
        w = old_word;
        case (store_type)
            TYPE_SB: begin
                case (lane)
                    2'd0:    w[7:0]   = new_data[7:0];
                    2'd1:    w[15:8]  = new_data[7:0];
                    2'd2:    w[23:16] = new_data[7:0];
                    default: w[31:24] = new_data[7:0];
                endcase
            end
            TYPE_SH: begin
                if (lane[1]) w[31:16] = new_data[15:0];
                else         w[15:0]  = new_data[15:0];
            end
            default: w = new_data;
        endcase
        return w;
    endfunction

    assign accept = req_valid && (state_q == S_IDLE);
    assign is_rmw = (store_type_sel == TYPE_SB) || (store_type_sel == TYPE_SH);

`ifdef STORE_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (store_type_sel == TYPE_SH)
            misaligned = addr[0];
        else if (store_type_sel != TYPE_SB)
            misaligned = (addr[1:0] != 2'b00);
    end
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        type_d  = type_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    type_d  = store_type_sel;
                    rdata_d = '0;
                    if (misaligned)  state_d = S_ERR;
                    else if (is_rmw) state_d = S_READ;
                    else             state_d = S_WRITE;
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter lands on RD_LAT in cycle T+MEM_RD_LAT, which is
                // exactly when the read data is valid.
                cnt_d = cnt_q + 3'd1;
                if (cnt_d == RD_LAT) begin
                    rdata_d = mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            type_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on the state and latched registers, so nothing on
    // req_* reaches mem_* within the same cycle.
    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
            end
            S_WAIT: mem_addr = {addr_q[31:2], 2'b00};
            S_WRITE: begin
                mem_wr_en = 1'b1;
                done      = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = merge_word(type_q, addr_q[1:0], wdata_q, rdata_q);
            end
            default: ;
        endcase
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign align_err = (state_q == S_ERR);
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  store_type_sel;

    // Instance with MEM_RD_LAT=1
    logic        req_valid1, req_ready1, done1, align_err1;
    logic [31:0] mem_addr1, mem_rdata1, mem_wdata1;
    logic        mem_rd_en1, mem_wr_en1;
    logic [31:0] mem_word1;
    logic [0:0]  rd_sh1;

    // Instance with MEM_RD_LAT=3
    logic        req_valid3, req_ready3, done3, align_err3;
    logic [31:0] mem_addr3, mem_rdata3, mem_wdata3;
    logic        mem_rd_en3, mem_wr_en3;
    logic [31:0] mem_word3;
    logic [2:0]  rd_sh3;

    int unsigned errors;
    int unsigned checks;

    store_merge_unit #(.MEM_RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .addr(addr), .wdata(wdata), .store_type_sel(store_type_sel),
        .done(done1), .align_err(align_err1),
        .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1), .mem_rdata(mem_rdata1),
        .mem_wr_en(mem_wr_en1), .mem_wdata(mem_wdata1)
    );

    store_merge_unit #(.MEM_RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .addr(addr), .wdata(wdata), .store_type_sel(store_type_sel),
        .done(done3), .align_err(align_err3),
        .mem_addr(mem_addr3), .mem_rd_en(mem_rd_en3), .mem_rdata(mem_rdata3),
        .mem_wr_en(mem_wr_en3), .mem_wdata(mem_wdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data is only valid exactly MEM_RD_LAT cycles after
    // the read strobe; any other cycle returns a poison pattern.
    always @(posedge clk) begin
        rd_sh1 <= mem_rd_en1;
        rd_sh3 <= {rd_sh3[1:0], mem_rd_en3};
    end
    assign mem_rdata1 = rd_sh1[0] ? mem_word1 : 32'hBAD0BAD0;
    assign mem_rdata3 = rd_sh3[2] ? mem_word3 : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sb/sh sequence on the latency-1 instance: accept at A, read at A+1,
    // write at A+3.
    task automatic rmw1(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] t, input logic [31:0] mw,
                        input logic [31:0] exp_w, input string tag);
        mem_word1      = mw;
        addr           = a;
        wdata          = d;
        store_type_sel = t;
        req_valid1     = 1'b1;
        check({tag, "_ready_A"}, 32'(req_ready1), 32'd1);
        step();
        req_valid1 = 1'b0;
        check({tag, "_rd_A1"}, 32'(mem_rd_en1), 32'd1);
        check({tag, "_addr_A1"}, mem_addr1, {a[31:2], 2'b00});
        step();
        check({tag, "_wr_A2"}, 32'(mem_wr_en1), 32'd0);
        step();
        check({tag, "_wr_A3"}, 32'(mem_wr_en1), 32'd1);
        check({tag, "_done_A3"}, 32'(done1), 32'd1);
        check({tag, "_wdata_A3"}, mem_wdata1, exp_w);
        check({tag, "_addr_A3"}, mem_addr1, {a[31:2], 2'b00});
        step();
        check({tag, "_idle"}, 32'(req_ready1), 32'd1);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        req_valid1     = 1'b0;
        req_valid3     = 1'b0;
        addr           = '0;
        wdata          = '0;
        store_type_sel = '0;
        mem_word1      = '0;
        mem_word3      = '0;
        rd_sh1         = '0;
        rd_sh3         = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(req_ready1), 32'd1);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_aerr", 32'(align_err1), 32'd0);
        check("rst_rd", 32'(mem_rd_en1), 32'd0);
        check("rst_wr", 32'(mem_wr_en1), 32'd0);
        check("rst_addr", mem_addr1, 32'd0);
        check("rst_wdata", mem_wdata1, 32'd0);

        // sw straight through
        addr = 32'h10; wdata = 32'hDEADBEEF; store_type_sel = 2'b00; req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        check("sw_wr", 32'(mem_wr_en1), 32'd1);
        check("sw_rd", 32'(mem_rd_en1), 32'd0);
        check("sw_done", 32'(done1), 32'd1);
        check("sw_addr", mem_addr1, 32'h10);
        check("sw_wdata", mem_wdata1, 32'hDEADBEEF);
        step();
        check("sw_after_wr", 32'(mem_wr_en1), 32'd0);
        check("sw_after_addr", mem_addr1, 32'd0);
        check("sw_after_wdata", mem_wdata1, 32'd0);
        check("sw_after_ready", 32'(req_ready1), 32'd1);

        // sb into every lane, including the spec vector (lane 3)
        rmw1(32'h13, 32'h000000AB, 2'b01, 32'h11223344, 32'hAB223344, "sb_l3");
        rmw1(32'h10, 32'h000000AB, 2'b01, 32'h11223344, 32'h112233AB, "sb_l0");
        rmw1(32'h11, 32'hFFFFFFAB, 2'b01, 32'h11223344, 32'h1122AB44, "sb_l1");
        rmw1(32'h12, 32'h000000AB, 2'b01, 32'h11223344, 32'h11AB3344, "sb_l2");

        // Back-to-back sh with req_valid held high; second accept at A+4
        mem_word1 = 32'h11223344;
        addr = 32'h22; wdata = 32'h0000CAFE; store_type_sel = 2'b10; req_valid1 = 1'b1;
        step();                      // A+1
        check("sh_busy_A1", 32'(req_ready1), 32'd0);
        addr = 32'h20;               // ignored while busy
        step();                      // A+2
        check("sh_busy_A2", 32'(req_ready1), 32'd0);
        step();                      // A+3
        check("sh_hi_wr", 32'(mem_wr_en1), 32'd1);
        check("sh_hi_wdata", mem_wdata1, 32'hCAFE3344);
        check("sh_hi_addr", mem_addr1, 32'h20);
        check("sh_busy_A3", 32'(req_ready1), 32'd0);
        step();                      // A+4 = B
        check("sh_ready_A4", 32'(req_ready1), 32'd1);
        step();                      // B+1
        req_valid1 = 1'b0;
        check("sh_lo_rd", 32'(mem_rd_en1), 32'd1);
        step();
        step();                      // B+3
        check("sh_lo_wr", 32'(mem_wr_en1), 32'd1);
        check("sh_lo_wdata", mem_wdata1, 32'h1122CAFE);
        step();

        // MEM_RD_LAT=3, sb with req_valid held high
        mem_word3 = 32'hFFFFFFFF;
        addr = 32'h01; wdata = 32'h00000055; store_type_sel = 2'b01; req_valid3 = 1'b1;
        check("l3_ready_A", 32'(req_ready3), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("l3_busy_A%0d", i), 32'(req_ready3), 32'd0);
            check($sformatf("l3_rd_A%0d", i), 32'(mem_rd_en3), (i == 1) ? 32'd1 : 32'd0);
            check($sformatf("l3_wr_A%0d", i), 32'(mem_wr_en3), (i == 5) ? 32'd1 : 32'd0);
        end
        req_valid3 = 1'b0;
        check("l3_wdata", mem_wdata3, 32'hFFFF55FF);
        check("l3_done", 32'(done3), 32'd1);
        check("l3_addr", mem_addr3, 32'h00);
        step();
        check("l3_ready_A6", 32'(req_ready3), 32'd1);

        // Reset during WAIT of an sb
        mem_word3 = 32'h11223344;
        addr = 32'h42; wdata = 32'h77; store_type_sel = 2'b01; req_valid3 = 1'b1;
        step();                      // A+1 READ
        req_valid3 = 1'b0;
        step();                      // A+2 WAIT
        check("rst_wait_addr", mem_addr3, 32'h40);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_ready", 32'(req_ready3), 32'd1);
        check("rst_mid_addr", mem_addr3, 32'd0);
        check("rst_mid_done", 32'(done3), 32'd0);
        begin
            int unsigned wr_seen;
            wr_seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (mem_wr_en3) wr_seen++;
                step();
            end
            check("rst_mid_no_wr", 32'(wr_seen), 32'd0);
        end

        // Misaligned sh
        mem_word1 = 32'h11223344;
`ifdef STORE_ALIGN_CHECK_EN
        addr = 32'h21; wdata = 32'h0000CAFE; store_type_sel = 2'b10; req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        check("mis_aerr", 32'(align_err1), 32'd1);
        check("mis_done", 32'(done1), 32'd0);
        check("mis_rd", 32'(mem_rd_en1), 32'd0);
        check("mis_wr", 32'(mem_wr_en1), 32'd0);
        check("mis_addr", mem_addr1, 32'd0);
        step();
        check("mis_aerr_clr", 32'(align_err1), 32'd0);
        check("mis_ready", 32'(req_ready1), 32'd1);
        // Misaligned sw also dropped
        addr = 32'h12; wdata = 32'h12345678; store_type_sel = 2'b11; req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        check("mis_sw_aerr", 32'(align_err1), 32'd1);
        check("mis_sw_wr", 32'(mem_wr_en1), 32'd0);
        step();
`else
        rmw1(32'h21, 32'h0000CAFE, 2'b10, 32'h11223344, 32'h1122CAFE, "mis_sh");
        check("mis_sh_aerr", 32'(align_err1), 32'd0);
        // sw ignores low address bits
        addr = 32'h12; wdata = 32'h12345678; store_type_sel = 2'b11; req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
        check("mis_sw_wr", 32'(mem_wr_en1), 32'd1);
        check("mis_sw_addr", mem_addr1, 32'h10);
        check("mis_sw_wdata", mem_wdata1, 32'h12345678);
        check("mis_sw_aerr", 32'(align_err1), 32'd0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
